// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared definitions for the memory responder and the cache fill logic
//   that talks to it: word width, default read latency, cache block size,
//   the request-kind encoding and the request decode helper.
package mem_responder_pkg;

    localparam int unsigned WORD_WIDTH      = 16;
    localparam int unsigned DEFAULT_LATENCY = 4;
    localparam int unsigned BLOCK_WORDS     = 8;

    typedef logic [WORD_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_READ,
        REQ_WRITE
    } req_kind_t;

    // Requests seen while rst is high are dropped entirely.
    function automatic req_kind_t decode_req(input logic rst,
                                             input logic enable,
                                             input logic wr);
        if (rst || !enable) begin
            return REQ_NONE;
        end
        return wr ? REQ_WRITE : REQ_READ;
    endfunction

endpackage

// File: rtl/mem_latency_pipe.sv
// mem_latency_pipe
//   LATENCY-deep shift register carrying {valid, address, data} for reads
//   in flight. Synchronous clear drops every in-flight entry.
//   Ports:
//     clk          clock
//     clear        synchronous clear of all stages
//     in_valid     a read is being issued this cycle
//     in_address   word-aligned address of the issued read
//     in_data      array word sampled at issue
//     out_valid    read returning this cycle
//     out_address  address of the returning read
//     out_data     data of the returning read
//     any_valid    OR of every stage valid bit (read in flight)
module mem_latency_pipe
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY    = DEFAULT_LATENCY,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_address,
    input  word_t                 in_data,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_address,
    output word_t                 out_data,
    output logic                  any_valid
);

    logic [LATENCY-1:0] valid_vec;

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        logic                  valid;
        logic [ADDR_WIDTH-1:0] address;
        word_t                 data;

        logic                  prev_valid;
        logic [ADDR_WIDTH-1:0] prev_address;
        word_t                 prev_data;

        if (i == 0) begin : g_first
            assign prev_valid   = in_valid;
            assign prev_address = in_address;
            assign prev_data    = in_data;
        end else begin : g_next
            assign prev_valid   = g_stage[i-1].valid;
            assign prev_address = g_stage[i-1].address;
            assign prev_data    = g_stage[i-1].data;
        end

        always_ff @(posedge clk) begin
            if (clear) begin
                valid   <= 1'b0;
                address <= '0;
                data    <= '0;
            end else begin
                valid   <= prev_valid;
                address <= prev_address;
                data    <= prev_data;
            end
        end

        assign valid_vec[i] = valid;
    end

    assign out_valid   = g_stage[LATENCY-1].valid;
    assign out_address = g_stage[LATENCY-1].address;
    assign out_data    = g_stage[LATENCY-1].data;
    assign any_valid   = |valid_vec;

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Fully pipelined 16-bit word memory model. One request per cycle, no
//   backpressure. Reads return exactly LATENCY cycles after issue, in
//   order; writes produce no response. Array contents survive reset.
//   Ports:
//     clk           clock
//     rst           synchronous active-high reset (flushes reads in flight)
//     enable        request strobe
//     wr            1 = write, 0 = read
//     address       byte address; bit 0 ignored
//     data_in       write data
//     data_out      read data; holds last returned word while data_valid low
//     data_valid    one-cycle pulse per returned read
//     data_address  address of the returned read, bit 0 forced 0
//     busy          a read is in flight
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY    = DEFAULT_LATENCY,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH-1:0] data_address,
    output logic                  busy
);

    localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 1);

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 1..8");
    end

    word_t                 mem [DEPTH];
    req_kind_t             req_kind;
    logic [ADDR_WIDTH-2:0] word_index;
    logic [ADDR_WIDTH-1:0] word_address;
    word_t                 read_word;
    logic                  unused_addr_bit;

    logic                  pipe_valid;
    logic [ADDR_WIDTH-1:0] pipe_address;
    word_t                 pipe_data;
    word_t                 held_data;

    assign req_kind        = decode_req(rst, enable, wr);
    assign word_index      = address[ADDR_WIDTH-1:1];
    assign word_address    = {word_index, 1'b0};
    assign unused_addr_bit = address[0];

    // Combinational read: a read sees the array as it stands before the
    // write committed at the same edge, so in-flight reads keep the
    // issue-time value and a read one cycle after a write sees new data.
    assign read_word = mem[word_index];

    always_ff @(posedge clk) begin
        if (req_kind == REQ_WRITE) begin
            mem[word_index] <= data_in;
        end
    end

    mem_latency_pipe #(
        .LATENCY    (LATENCY),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pipe (
        .clk         (clk),
        .clear       (rst),
        .in_valid    (req_kind == REQ_READ),
        .in_address  (word_address),
        .in_data     (read_word),
        .out_valid   (pipe_valid),
        .out_address (pipe_address),
        .out_data    (pipe_data),
        .any_valid   (busy)
    );

    // Bubbles shift through the pipe too, so the last returned word is
    // kept separately to hold data_out steady between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_data <= '0;
        end else if (pipe_valid) begin
            held_data <= pipe_data;
        end
    end

    assign data_valid   = pipe_valid;
    assign data_address = pipe_address;
    assign data_out     = pipe_valid ? pipe_data : held_data;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Scoreboard bench for mem_responder (LATENCY = 4) plus a short directed
//   check of a LATENCY = 1 instance.
module tb_mem_responder;

    localparam int unsigned LAT = 4;

    typedef struct {
        int          due;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_valid;
    logic [15:0] data_address;
    logic        busy;

    logic        en1 = 1'b0;
    logic        wr1 = 1'b0;
    logic [15:0] addr1 = '0;
    logic [15:0] din1 = '0;
    logic [15:0] dout1;
    logic        dv1;
    logic [15:0] daddr1;
    logic        busy1;

    int          n_vectors = 0;
    int          n_miscompares = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [15:0] model [int];
    logic [15:0] last_out = '0;

    always #5 clk = ~clk;

    mem_responder #(
        .LATENCY    (LAT),
        .ADDR_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .wr           (wr),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_address (data_address),
        .busy         (busy)
    );

    mem_responder #(
        .LATENCY    (1),
        .ADDR_WIDTH (16)
    ) dut_lat1 (
        .clk          (clk),
        .rst          (rst),
        .enable       (en1),
        .wr           (wr1),
        .address      (addr1),
        .data_in      (din1),
        .data_out     (dout1),
        .data_valid   (dv1),
        .data_address (daddr1),
        .busy         (busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                check_eq("rst_valid", data_valid, 0);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_data", data_out, 16'h0000);
                check_eq("rst_addr", data_address, 16'h0000);
                last_out = '0;
            end else begin
                check_eq("busy", busy, (sb.size() != 0));
                if (data_valid) begin
                    if (sb.size() == 0) begin
                        check_eq("spurious_valid", data_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("valid_cycle", cyc, e.due);
                        check_eq("data", data_out, e.data);
                        check_eq("data_address", data_address, e.addr);
                        last_out = e.data;
                    end
                end else begin
                    if (sb.size() != 0 && sb[0].due <= cyc) begin
                        check_eq("missing_valid", data_valid, 1);
                        void'(sb.pop_front());
                    end
                    check_eq("hold_data", data_out, last_out);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic en, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        int   idx;
        @(negedge clk);
        rst = r; enable = en; wr = w; address = a; data_in = d;
        idx = int'(a[15:1]);
        if (r) begin
            sb.delete();
        end else if (en) begin
            if (w) begin
                model[idx] = d;
            end else begin
                e.due  = cyc + LAT;
                e.addr = {a[15:1], 1'b0};
                e.data = model.exists(idx) ? model[idx] : 16'h0000;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state is checked by the monitor while rst is high.
        repeat (3) @(negedge clk);
        idle();

        // Write then read next cycle.
        drive(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        drain();

        // Block fill: preload, then eight back-to-back reads.
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'b1, 1'b1, 16'(16'h0040 + 2 * i), 16'(16'h1000 + i));
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'b1, 1'b0, 16'(16'h0040 + 2 * i), 16'h0000);
        drain();

        // Write behind an in-flight read of the same word.
        drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1111);
        idle();
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h2222);
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        drain();

        // Odd byte address.
        drive(1'b0, 1'b1, 1'b1, 16'h0022, 16'h3C3C);
        drive(1'b0, 1'b1, 1'b0, 16'h0023, 16'h0000);
        drain();

        // Address wrap at the top of the space.
        drive(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h7E7E);
        drive(1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0000);
        drain();

        // Mixed traffic with bubbles.
        for (int i = 0; i < 16; i++)
            drive(1'b0, 1'b1, 1'b1, 16'(16'h0100 + 2 * i), 16'($urandom));
        for (int i = 0; i < 60; i++) begin
            logic        en;
            logic        w;
            logic [15:0] a;
            en = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 2) == 0);
            a  = 16'h0100 | 16'($urandom_range(0, 31));
            drive(1'b0, en, w, a, 16'($urandom));
        end
        drain();

        // Reset mid-fill; a write presented during rst must be ignored.
        drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 16'h0044, 16'h0000);
        idle();
        drive(1'b1, 1'b1, 1'b1, 16'h0046, 16'hDEAD);
        drain();
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'b1, 1'b0, 16'(16'h0040 + 2 * i), 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        drain();

        // LATENCY = 1 instance: write, read odd address next cycle.
        @(negedge clk);
        en1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0022; din1 = 16'hC3A5;
        @(negedge clk);
        wr1 = 1'b0; addr1 = 16'h0023; din1 = 16'h0000;
        @(negedge clk);
        en1 = 1'b0;
        check_eq("lat1_valid", dv1, 1);
        check_eq("lat1_data", dout1, 16'hC3A5);
        check_eq("lat1_addr", daddr1, 16'h0022);
        @(negedge clk);
        check_eq("lat1_valid_end", dv1, 0);
        check_eq("lat1_hold", dout1, 16'hC3A5);
        check_eq("lat1_busy", busy1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from read issue to read data valid; legal range 1..8.
REQ-002 Parameter ADDR_WIDTH, default 16, byte-address width; array depth = 2^(ADDR_WIDTH-1) 16-bit words.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  request strobe; one request accepted per cycle when high.
REQ-006 wr  input  1  request type: 1 = write, 0 = read; ignored when enable low.
REQ-007 address  input  ADDR_WIDTH  byte address of request; bit 0 ignored.
REQ-008 data_in  input  16  write data.
REQ-009 data_out  output  16  read data; meaningful only while data_valid high.
REQ-010 data_valid  output  1  one-cycle pulse per returned read word.
REQ-011 data_address  output  ADDR_WIDTH  address of the read returned this cycle, bit 0 forced 0.
REQ-012 busy  output  1  high while any read is in flight (issued, not yet returned).

Function
REQ-013 Fully pipelined: a request is accepted every cycle enable is high; no backpressure, no ready signal.
REQ-014 Write: array word address[ADDR_WIDTH-1:1] updated with data_in at the edge where enable & wr sampled high; no response generated.
REQ-015 Read: array word sampled at the issue edge; data_out/data_valid/data_address present exactly LATENCY cycles after issue edge (issue cycle N -> valid cycle N+LATENCY).
REQ-016 Back-to-back reads return back-to-back, in issue order, one per cycle, no gaps, no reordering.
REQ-017 Read issued the cycle after a write to the same word returns the written value.
REQ-018 Write to a word while an earlier read of that word is in flight: in-flight read returns the old (issue-time) value.
REQ-019 enable low: no array change; bubble propagates, data_valid low LATENCY cycles later.
REQ-020 data_out holds its last returned value while data_valid low (no X, no zeroing).
REQ-021 busy = OR of in-flight valid bits; busy low the cycle after the last read's data_valid pulse, unless new reads issued.
REQ-022 Address wrap: only address[ADDR_WIDTH-1:1] indexes the array; no out-of-range condition exists.
REQ-023 Eight consecutive reads at addresses B, B+2 ... B+14 (one 16-byte cache block fill) return eight consecutive valid words starting LATENCY cycles after first issue.

Reset
REQ-024 While rst high: all in-flight reads discarded, data_valid = 0, busy = 0, data_out = 16'h0000, data_address = 0.
REQ-025 Requests sampled in a cycle with rst high are ignored (no write, no read issued).
REQ-026 Array contents are not cleared by rst; data written before reset survives it.
REQ-027 Reset mid-fill: reads issued before rst produce no data_valid pulse after rst deasserts.

Structure
REQ-028 Shared package/include holds WORD_WIDTH = 16, default LATENCY = 4, BLOCK_WORDS = 8 (shared with the cache fill FSM).
REQ-029 One sub-module, mem_latency_pipe: LATENCY-deep shift of {valid, address, data} with synchronous clear; array and request decode stay in mem_responder.

Verification
REQ-030 Write 16'hBEEF to 16'h0010, then read 16'h0010 next cycle -> data_valid at issue+4, data_out 16'hBEEF, data_address 16'h0010.
REQ-031 Preload 16'h0040..16'h004E with 16'h1000..16'h1007, eight back-to-back reads -> eight consecutive valid pulses, data 16'h1000..16'h1007 in order, busy falls one cycle after the eighth pulse.
REQ-032 Read 16'h0020 (holds 16'h1111), write 16'h2222 to 16'h0020 next cycle -> returned data 16'h1111; subsequent read returns 16'h2222.
REQ-033 Issue three reads, assert rst for one cycle two cycles later -> no data_valid pulse afterwards, busy 0, memory contents unchanged.
REQ-034 Read 16'h0023 (odd) -> data_address 16'h0022, data of word 16'h0022; LATENCY = 1 build -> valid in the cycle after issue.
